// File: rtl/balls_collision_pair_scanner.sv
// Purpose : per-frame scan of all ball pairs; latches the first overlapping active pair.
// Latency : pair k of the scan is tested in cycle t+1+k after startOfFrame at t; a hit is visible at t+2+k.
// Backpres: none; startOfFrame always wins and restarts the scan from a fresh snapshot.
//
// Ports:
//   clk, resetN (async active-low), startOfFrame (1-cycle pulse)
//   ball_active, topLeftX/Y_VEC_in, Xspeed/Yspeed_VEC_in : per-ball state, sampled on startOfFrame
//   balls_collide : two-hot mask of the reported pair, Balls_col_ID : {higher ID, lower ID}
//   col_valid : hit latched this frame, scan_busy : pairs still being tested
// Optional feature macro: COLLISION_APPROACH_CHECK_EN -- when defined, an overlapping pair is
// only reported if the balls are moving towards each other (relative velocity . offset < 0).
module balls_collision_pair_scanner #(
  parameter int NUM_BALLS    = 3,
  parameter int BALL_DIAM_SQ = 1024
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic [NUM_BALLS:0]          ball_active,
  input  logic [NUM_BALLS:0][10:0]    topLeftX_VEC_in,
  input  logic [NUM_BALLS:0][10:0]    topLeftY_VEC_in,
  input  logic [NUM_BALLS:0][10:0]    Xspeed_VEC_in,
  input  logic [NUM_BALLS:0][10:0]    Yspeed_VEC_in,
  output logic [NUM_BALLS:0]          balls_collide,
  output logic [1:0][3:0]             Balls_col_ID,
  output logic                        col_valid,
  output logic                        scan_busy
);

  localparam int          IW      = $clog2(NUM_BALLS + 1);
  localparam logic [IW-1:0] LAST_J = IW'(NUM_BALLS);
  localparam logic [IW-1:0] LAST_I = IW'(NUM_BALLS - 1);
  localparam logic [24:0] DIAM_SQ = 25'(BALL_DIAM_SQ);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;
  state_t state, state_nxt;

  // Frame snapshot: the scan never looks at the live inputs.
  logic [NUM_BALLS:0][10:0] snap_x, snap_y, snap_vx, snap_vy;
  logic [NUM_BALLS:0]       snap_act;
  logic [IW-1:0]            idx_i, idx_j;

  logic signed [11:0] dx, dy;
  logic signed [23:0] dx_ext, dy_ext, dx_sq, dy_sq;
  logic [24:0]        d2;
  logic               overlap, approach, hit, last_pair;
  logic               latch_hit, advance;
  logic [NUM_BALLS:0] pair_mask;

  // Offsets are formed at 12 bits so the difference of two 11-bit values cannot wrap.
  assign dx     = {snap_x[idx_j][10], snap_x[idx_j]} - {snap_x[idx_i][10], snap_x[idx_i]};
  assign dy     = {snap_y[idx_j][10], snap_y[idx_j]} - {snap_y[idx_i][10], snap_y[idx_i]};
  assign dx_ext = {{12{dx[11]}}, dx};
  assign dy_ext = {{12{dy[11]}}, dy};
  assign dx_sq  = dx_ext * dx_ext;
  assign dy_sq  = dy_ext * dy_ext;
  assign d2     = {1'b0, dx_sq} + {1'b0, dy_sq};
  assign overlap = (d2 < DIAM_SQ);

`ifdef COLLISION_APPROACH_CHECK_EN
  logic signed [11:0] dvx, dvy;
  logic signed [23:0] dvx_ext, dvy_ext, pvx, pvy;
  logic signed [24:0] dot;

  assign dvx     = {snap_vx[idx_j][10], snap_vx[idx_j]} - {snap_vx[idx_i][10], snap_vx[idx_i]};
  assign dvy     = {snap_vy[idx_j][10], snap_vy[idx_j]} - {snap_vy[idx_i][10], snap_vy[idx_i]};
  assign dvx_ext = {{12{dvx[11]}}, dvx};
  assign dvy_ext = {{12{dvy[11]}}, dvy};
  assign pvx     = dvx_ext * dx_ext;
  assign pvy     = dvy_ext * dy_ext;
  assign dot     = {pvx[23], pvx} + {pvy[23], pvy};
  // Negative dot product: the gap between the centres is shrinking.
  assign approach = dot[24];
`else
  assign approach = 1'b1;
`endif

  assign hit       = overlap & snap_act[idx_i] & snap_act[idx_j] & approach;
  assign last_pair = (idx_i == LAST_I) && (idx_j == LAST_J);
  assign scan_busy = (state == SCAN);

  always_comb begin
    pair_mask        = '0;
    pair_mask[idx_i] = 1'b1;
    pair_mask[idx_j] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_hit = 1'b0;
    advance   = 1'b0;
    if (startOfFrame) begin
      // A restart overrides any hit that would be latched this cycle.
      state_nxt = SCAN;
    end else begin
      case (state)
        SCAN: begin
          if (hit) begin
            state_nxt = HOLD;
            latch_hit = 1'b1;
          end else if (last_pair) begin
            state_nxt = IDLE;
          end else begin
            advance = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      snap_x        <= '0;
      snap_y        <= '0;
      snap_vx       <= '0;
      snap_vy       <= '0;
      snap_act      <= '0;
      idx_i         <= '0;
      idx_j         <= '0;
      balls_collide <= '0;
      Balls_col_ID  <= '0;
      col_valid     <= 1'b0;
    end else if (startOfFrame) begin
      snap_x        <= topLeftX_VEC_in;
      snap_y        <= topLeftY_VEC_in;
      snap_vx       <= Xspeed_VEC_in;
      snap_vy       <= Yspeed_VEC_in;
      snap_act      <= ball_active;
      idx_i         <= '0;
      idx_j         <= IW'(1);
      balls_collide <= '0;
      Balls_col_ID  <= '0;
      col_valid     <= 1'b0;
    end else begin
      if (latch_hit) begin
        balls_collide   <= pair_mask;
        Balls_col_ID[0] <= 4'(idx_i);
        Balls_col_ID[1] <= 4'(idx_j);
        col_valid       <= 1'b1;
      end
      if (advance) begin
        // Row exhausted: move to the next i and restart j just above it.
        if (idx_j == LAST_J) begin
          idx_i <= idx_i + IW'(1);
          idx_j <= idx_i + IW'(2);
        end else begin
          idx_j <= idx_j + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_balls_collision_pair_scanner.sv
// Purpose : directed bench for balls_collision_pair_scanner with a per-cycle reference model.
// Latency : model predicts busy/hit timing from the pair index of the first hit in each frame.
// Backpres: none; stimulus is applied 2 ns after the rising edge, outputs checked on the falling edge.
module tb_balls_collision_pair_scanner;

  localparam int NP = 6;  // pairs for 4 balls

  logic            clk;
  logic            resetN;
  logic            sof;
  logic [3:0]      act;
  logic [3:0][10:0] x, y, vx, vy;
  logic [3:0]      balls_collide;
  logic [1:0][3:0] Balls_col_ID;
  logic            col_valid;
  logic            scan_busy;

  int n_checks = 0;
  int n_fail   = 0;

  balls_collision_pair_scanner #(.NUM_BALLS(3), .BALL_DIAM_SQ(1024)) dut (
    .clk             (clk),
    .resetN          (resetN),
    .startOfFrame    (sof),
    .ball_active     (act),
    .topLeftX_VEC_in (x),
    .topLeftY_VEC_in (y),
    .Xspeed_VEC_in   (vx),
    .Yspeed_VEC_in   (vy),
    .balls_collide   (balls_collide),
    .Balls_col_ID    (Balls_col_ID),
    .col_valid       (col_valid),
    .scan_busy       (scan_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: first pair (in scan order) that overlaps, is active on both sides and,
  // if enabled, is approaching. k = -1 when nothing qualifies.
  task automatic find_hit(output int k, output int hi, output int hj);
    int n, ddx, ddy, d2, dot;
    bit h;
    k = -1; hi = 0; hj = 0; n = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        if (k < 0) begin
          ddx = int'($signed(x[j])) - int'($signed(x[i]));
          ddy = int'($signed(y[j])) - int'($signed(y[i]));
          d2  = ddx * ddx + ddy * ddy;
          h   = (d2 < 1024) && act[i] && act[j];
          dot = (int'($signed(vx[j])) - int'($signed(vx[i]))) * ddx +
                (int'($signed(vy[j])) - int'($signed(vy[i]))) * ddy;
`ifdef COLLISION_APPROACH_CHECK_EN
          h = h && (dot < 0);
`endif
          if (h) begin
            k = n; hi = i; hj = j;
          end
        end
        n++;
      end
    end
  endtask

  // Cycle model: at a frame start it decides the outcome, then counts down the scan.
  logic       m_busy = 1'b0, m_valid = 1'b0;
  logic [3:0] m_col = '0;
  int         m_id0 = 0, m_id1 = 0, m_rem = 0, m_k = -1, m_i = 0, m_j = 0;
  int         fk, fi, fj;

  always @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_col <= '0; m_id0 <= 0; m_id1 <= 0; m_rem <= 0;
    end else if (sof) begin
      find_hit(fk, fi, fj);
      m_k <= fk; m_i <= fi; m_j <= fj;
      m_busy <= 1'b1; m_valid <= 1'b0; m_col <= '0; m_id0 <= 0; m_id1 <= 0;
      m_rem <= (fk >= 0) ? fk + 1 : NP;
    end else if (m_busy) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_busy <= 1'b0;
        if (m_k >= 0) begin
          m_valid <= 1'b1;
          m_col   <= 4'((1 << m_i) | (1 << m_j));
          m_id0   <= m_i;
          m_id1   <= m_j;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_busy",  int'(scan_busy),       int'(m_busy));
    chk("model_valid", int'(col_valid),       int'(m_valid));
    chk("model_mask",  int'(balls_collide),   int'(m_col));
    chk("model_id0",   int'(Balls_col_ID[0]), m_id0);
    chk("model_id1",   int'(Balls_col_ID[1]), m_id1);
  end

  task automatic set_ball(input int b, input int px, input int py, input int pvx, input int pvy);
    x[b] = 11'(px); y[b] = 11'(py); vx[b] = 11'(pvx); vy[b] = 11'(pvy);
  endtask

  task automatic far_layout();
    act = 4'b1111;
    set_ball(0, -800, -800, 0, 0);
    set_ball(1, -400,  400, 0, 0);
    set_ball(2,  400, -400, 0, 0);
    set_ball(3,  800,  800, 0, 0);
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Leaves time in cycle t+1 where t is the edge that samples the pulse.
  task automatic pulse();
    @(posedge clk); #2 sof = 1'b1;
    @(posedge clk); #2 sof = 1'b0;
  endtask

  task automatic config_late();  // hit only on the last pair (2,3)
    far_layout();
    set_ball(2, 300, 300, 16, 0);
    set_ball(3, 310, 300, 0, 0);
  endtask

  task automatic config_first();  // balls 0 and 2 approaching, pair index 1
    far_layout();
    set_ball(0, 100, 100, 16, 0);
    set_ball(2, 120, 100, 0, 0);
  endtask

  int k, hi, hj;

  initial begin
    sof = 1'b0;
    far_layout();
    resetN = 1'b1;
    #1 resetN = 1'b0;
    repeat (2) @(posedge clk);
    #2 resetN = 1'b1;
    wait_edges(1);
    chk("reset_valid", int'(col_valid), 0);
    chk("reset_busy",  int'(scan_busy), 0);
    chk("reset_mask",  int'(balls_collide), 0);

    // Approaching overlap of 0 and 2
    config_first();
    find_hit(k, hi, hj);
    chk("model_t1_k", k, 1);
    pulse();
    chk("t1_busy_t1", int'(scan_busy), 1);
    wait_edges(1);
    chk("t1_valid_t2", int'(col_valid), 0);
    wait_edges(1);
    chk("t1_valid_t3", int'(col_valid), 1);
    chk("t1_mask",     int'(balls_collide), 5);
    chk("t1_id0",      int'(Balls_col_ID[0]), 0);
    chk("t1_id1",      int'(Balls_col_ID[1]), 2);
    chk("t1_busy_t3",  int'(scan_busy), 0);
    wait_edges(3);

    // Boundary: d2 = 1024 is not an overlap
    far_layout();
    set_ball(0, 100, 100, 16, 0);
    set_ball(1, 132, 100, 0, 0);
    find_hit(k, hi, hj);
    chk("model_t2a_k", k, -1);
    pulse();
    wait_edges(5);
    chk("t2a_busy_t6", int'(scan_busy), 1);
    wait_edges(1);
    chk("t2a_busy_t7",  int'(scan_busy), 0);
    chk("t2a_valid_t7", int'(col_valid), 0);
    set_ball(1, 131, 100, 0, 0);
    find_hit(k, hi, hj);
    chk("model_t2b_k", k, 0);
    pulse();
    wait_edges(1);
    chk("t2b_valid", int'(col_valid), 1);
    chk("t2b_mask",  int'(balls_collide), 3);
    wait_edges(2);

    // Two qualifying pairs: only (1,2) is reported
    far_layout();
    set_ball(1, 200, 200, 16, 0);
    set_ball(2, 220, 200, 0, 0);
    set_ball(3, 240, 200, -16, 0);
    find_hit(k, hi, hj);
    chk("model_t3_k", k, 3);
    pulse();
    wait_edges(3);
    chk("t3_valid_t4", int'(col_valid), 0);
    wait_edges(1);
    chk("t3_valid_t5", int'(col_valid), 1);
    chk("t3_id0",      int'(Balls_col_ID[0]), 1);
    chk("t3_id1",      int'(Balls_col_ID[1]), 2);
    chk("t3_mask",     int'(balls_collide), 6);
    wait_edges(4);
    far_layout();
    @(posedge clk); #2 sof = 1'b1;
    chk("t3_held_at_sof", int'(col_valid), 1);
    @(posedge clk); #2 sof = 1'b0;
    chk("t3_clear_valid", int'(col_valid), 0);
    chk("t3_clear_mask",  int'(balls_collide), 0);
    wait_edges(7);

    // Separating overlap
    far_layout();
    set_ball(0, 100, 100, -16, 0);
    set_ball(1, 110, 100, 16, 0);
    find_hit(k, hi, hj);
`ifdef COLLISION_APPROACH_CHECK_EN
    chk("model_t4_k", k, -1);
`else
    chk("model_t4_k", k, 0);
`endif
    pulse();
    wait_edges(1);
`ifdef COLLISION_APPROACH_CHECK_EN
    chk("t4_valid", int'(col_valid), 0);
`else
    chk("t4_valid", int'(col_valid), 1);
`endif
    wait_edges(6);

    // Approaching overlap but ball 1 pocketed
    far_layout();
    set_ball(0, 100, 100, 16, 0);
    set_ball(1, 120, 100, 0, 0);
    act = 4'b1101;
    find_hit(k, hi, hj);
    chk("model_t4b_k", k, -1);
    pulse();
    wait_edges(6);
    chk("t4b_valid", int'(col_valid), 0);
    chk("t4b_busy",  int'(scan_busy), 0);

    // Restart at t+2 with new positions; live inputs then change again
    config_late();
    find_hit(k, hi, hj);
    chk("model_t5_k", k, 5);
    pulse();
    @(posedge clk); #2;
    config_first();
    sof = 1'b1;
    @(posedge clk); #2 sof = 1'b0;
    config_late();
    wait_edges(1);
    chk("t5_valid_t4", int'(col_valid), 0);
    wait_edges(1);
    chk("t5_valid_t5", int'(col_valid), 1);
    chk("t5_id0",      int'(Balls_col_ID[0]), 0);
    chk("t5_id1",      int'(Balls_col_ID[1]), 2);
    wait_edges(4);
    chk("t5_id1_held", int'(Balls_col_ID[1]), 2);

    // Reset in the middle of a scan
    config_late();
    pulse();
    wait_edges(2);
    resetN = 1'b0;
    #1;
    chk("rst_busy",  int'(scan_busy), 0);
    chk("rst_valid", int'(col_valid), 0);
    wait_edges(2);
    resetN = 1'b1;
    wait_edges(10);
    chk("post_rst_valid", int'(col_valid), 0);
    chk("post_rst_busy",  int'(scan_busy), 0);
    chk("post_rst_mask",  int'(balls_collide), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
